bitty_fetch_unit: RTL and testbench
===================================

// Module: bitty_fetch_unit
// PURPOSE
//  Upstream sequencer for bitty_core: owns the program counter and fetches instruction words
//  from a synchronous instruction memory. Drives core run/instruction, waits for done, then advances the PC.
//  Services core load/store: en_memory_inst (read) / en_memory_write (write) accesses at memory_addr.
//  Stops on the halt word and reports halted.
// PARAMETERS
//  ADDR_W     8        width of PC, imem and dmem addresses
//  PC_RESET   0        PC value after reset
//  HALT_INSN  16'hFFFF instruction word that stops fetching (never issued to the core)
// PORTS
//  clk              in   1       rising-edge clock
//  reset            in   1       synchronous, active-high
//  start            in   1       pulse: leave IDLE/HALTED and begin fetching at current PC
//  imem_addr        out  ADDR_W  instruction memory address
//  imem_rd_en       out  1       instruction read strobe
//  imem_rdata       in   16      instruction word, valid 1 cycle after imem_rd_en
//  dmem_addr        out  ADDR_W  data memory address = core_memory_addr[ADDR_W-1:0]
//  dmem_rd_en       out  1       data read strobe
//  dmem_wr_en       out  1       data write strobe
//  dmem_wdata       out  16      = core_data_to_memory
//  dmem_rdata       in   16      read data, valid 1 cycle after dmem_rd_en
//  core_run         out  1       one-cycle run pulse to bitty_core
//  core_instruction out  16      instruction / load data to bitty_core (registered)
//  core_done        in   1       bitty_core done
//  core_en_mem_inst in   1       core requests memory access
//  core_en_mem_wr   in   1       qualifies access as a write
//  core_memory_addr in   16      core memory address
//  core_data_to_mem in   16      core store data
//  pc               out  ADDR_W  current program counter
//  halted           out  1       HALT_INSN fetched
// BEHAVIOUR
//  Reset: state IDLE, pc=PC_RESET, core_instruction=0.
//   All strobes (imem_rd_en, dmem_rd_en, dmem_wr_en, core_run) and halted = 0.
//  FSM states: IDLE, FETCH, WAIT, ISSUE, EXEC, MEM_RD, HALTED.
//  IDLE:   start -> FETCH.
//  FETCH:  imem_rd_en=1 and imem_addr=pc for one cycle -> WAIT.
//  WAIT:   latch imem_rdata.
//          If imem_rdata==HALT_INSN -> HALTED; pc is not advanced and core_instruction is not updated.
//          Otherwise core_instruction<=imem_rdata -> ISSUE.
//  ISSUE:  core_run=1 for exactly one cycle -> EXEC.
//  EXEC:   core_done=1 -> pc<=pc+1 (wraps modulo 2^ADDR_W) -> FETCH.
//          Else if core_en_mem_inst & core_en_mem_wr: dmem_wr_en=1 this cycle (combinational, single cycle per access), stay EXEC.
//          Else if core_en_mem_inst & !core_en_mem_wr: dmem_rd_en=1 -> MEM_RD.
//  MEM_RD: core_instruction<=dmem_rdata, held until next fetch -> EXEC.
//          Further dmem_rd_en requests are blocked until core_en_mem_inst has deasserted once.
//          Implementation: an armed flag, cleared on issue, set when en_mem_inst is low.
//  Priority: core_done wins over a simultaneous memory request. The request is dropped and the pc still advances.
//  HALTED: halted=1. start -> clear halted, pc<=PC_RESET, -> FETCH.
//  start is ignored in every state except IDLE and HALTED.
//  Fetch-to-run latency: 3 cycles, from FETCH entry to the core_run pulse.
//  Reset mid-instruction: returns to IDLE next edge; no strobe is asserted in the reset cycle.
//  Address truncation: upper core_memory_addr bits above ADDR_W are ignored.
// STRUCTURE
//  bitty_pkg holds the fetch state enum (3-bit localparams) and HALT_INSN default.
//  Sub-module bitty_pc: ADDR_W counter with load (PC_RESET) and increment enables.
//  Memory arbitration and FSM stay inline.
// TESTING
//  - imem[0..2]={16'h0001,16'h0002,FFFF}, start, core_done 2 cycles after each run:
//    -> run pulses for words 1,2; halted=1; pc=2.
//  - Load: core asserts en_mem_inst, addr=16'h0010, dmem[0x10]=16'hBEEF:
//    -> dmem_rd_en one cycle; core_instruction=BEEF next cycle; held until done.
//  - Store: en_mem_inst & en_mem_wr, addr=0x20, data=0x1234:
//    -> dmem_wr_en=1, dmem_addr=0x20, dmem_wdata=0x1234, single cycle.
//  - core_done coincident with a load request -> no dmem_rd_en; pc increments.
//  - pc=2^ADDR_W-1, done -> pc wraps to 0; fetch continues at imem[0].
//  - Reset asserted in EXEC -> next cycle: state IDLE, pc=PC_RESET, all strobes 0; start is required to resume.

Source files
------------

// File: rtl/bitty_pkg.sv
// Shared types for the bitty fetch unit.
// Fetch FSM encoding and the default halt word.
package bitty_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_EXEC   = 3'd4;
  localparam logic [2:0] ST_MEM_RD = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_WAIT   = ST_WAIT,
    S_ISSUE  = ST_ISSUE,
    S_EXEC   = ST_EXEC,
    S_MEM_RD = ST_MEM_RD,
    S_HALTED = ST_HALTED
  } fetch_state_e;

  localparam logic [15:0] HALT_INSN_DEF = 16'hFFFF;

  function automatic logic is_halt(
    input logic [15:0] insn,
    input logic [15:0] halt_word
  );
    return insn == halt_word;
  endfunction

endpackage

// File: rtl/bitty_fetch_unit_if.sv
// Memory and core-side bus of the bitty fetch unit.
// master = fetch unit, slave = memories plus core.
interface bitty_fetch_unit_if #(
  parameter int ADDR_W = 8
);

  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd_en;
  logic [15:0]       imem_rdata;

  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_rd_en;
  logic              dmem_wr_en;
  logic [15:0]       dmem_wdata;
  logic [15:0]       dmem_rdata;

  logic              core_run;
  logic [15:0]       core_instruction;
  logic              core_done;
  logic              core_en_mem_inst;
  logic              core_en_mem_wr;
  logic [15:0]       core_memory_addr;
  logic [15:0]       core_data_to_mem;

  modport master (
    output imem_addr,
    output imem_rd_en,
    input  imem_rdata,
    output dmem_addr,
    output dmem_rd_en,
    output dmem_wr_en,
    output dmem_wdata,
    input  dmem_rdata,
    output core_run,
    output core_instruction,
    input  core_done,
    input  core_en_mem_inst,
    input  core_en_mem_wr,
    input  core_memory_addr,
    input  core_data_to_mem
  );

  modport slave (
    input  imem_addr,
    input  imem_rd_en,
    output imem_rdata,
    input  dmem_addr,
    input  dmem_rd_en,
    input  dmem_wr_en,
    input  dmem_wdata,
    output dmem_rdata,
    input  core_run,
    input  core_instruction,
    output core_done,
    output core_en_mem_inst,
    output core_en_mem_wr,
    output core_memory_addr,
    output core_data_to_mem
  );

endinterface

// File: rtl/bitty_pc.sv
// Program counter for the bitty fetch unit.
// Load to the reset vector or increment, wrapping modulo 2^ADDR_W.
module bitty_pc #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset || i_load) begin
      r_pc <= PC_RESET;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/bitty_fetch_unit.sv
// Fetch sequencer for bitty_core: fetches, issues, services
// core loads/stores and stops on the halt word.
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] PC_RESET  = '0,
  parameter logic [15:0]       HALT_INSN = HALT_INSN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  bitty_fetch_unit_if.master  bus,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted
);

  fetch_state_e r_state;
  fetch_state_e w_next;

  logic [15:0] r_insn;
  logic        r_armed;

  logic w_pc_load;
  logic w_pc_inc;
  logic w_in_exec;
  logic w_mem_req;
  logic w_rd_go;
  logic w_wr_go;
  logic w_halt_word;

  bitty_pc #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (PC_RESET)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_pc_load),
    .i_inc  (w_pc_inc),
    .o_pc   (pc)
  );

  assign w_halt_word = is_halt(bus.imem_rdata, HALT_INSN);
  assign w_in_exec   = (r_state == S_EXEC) && !reset;

  // core_done outranks any memory request seen in the same cycle
  assign w_mem_req = w_in_exec
                   && bus.core_en_mem_inst
                   && !bus.core_done;
  assign w_wr_go   = w_mem_req && bus.core_en_mem_wr;
  assign w_rd_go   = w_mem_req && !bus.core_en_mem_wr
                   && r_armed;

  always_comb begin
    w_next    = r_state;
    w_pc_load = 1'b0;
    w_pc_inc  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_halt_word) w_next = S_HALTED;
        else             w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        if (bus.core_done) begin
          w_pc_inc = 1'b1;
          w_next   = S_FETCH;
        end else if (w_rd_go) begin
          w_next = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        w_next = S_EXEC;
      end
      S_HALTED: begin
        if (start) begin
          w_pc_load = 1'b1;
          w_next    = S_FETCH;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_insn  <= '0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && !w_halt_word) begin
        r_insn <= bus.imem_rdata;
      end
      if (r_state == S_MEM_RD) begin
        r_insn <= bus.dmem_rdata;
      end
      // one load per request: re-arm only after en_mem_inst drops
      if (w_rd_go) begin
        r_armed <= 1'b0;
      end else if (!bus.core_en_mem_inst) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.imem_rd_en = (r_state == S_FETCH) && !reset;

  assign bus.dmem_addr  = bus.core_memory_addr[ADDR_W-1:0];
  assign bus.dmem_wdata = bus.core_data_to_mem;
  assign bus.dmem_rd_en = w_rd_go;
  assign bus.dmem_wr_en = w_wr_go;

  assign bus.core_run         = (r_state == S_ISSUE) && !reset;
  assign bus.core_instruction = r_insn;

  assign halted = (r_state == S_HALTED);

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Bench for bitty_fetch_unit: memory models, scripted core,
// scoreboard of expected issued instruction words.
module tb_bitty_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pc;
  logic       halted;

  always #5 clk = ~clk;

  bitty_fetch_unit_if #(.ADDR_W(8)) bus ();

  bitty_fetch_unit #(
    .ADDR_W    (8),
    .PC_RESET  (8'd0),
    .HALT_INSN (16'hFFFF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
  );

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] exp_q [$];

  int n_chk  = 0;
  int n_err  = 0;
  int n_runs = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= imem[bus.imem_addr];
    if (bus.dmem_rd_en) bus.dmem_rdata <= dmem[bus.dmem_addr];
    if (bus.dmem_wr_en) dmem[bus.dmem_addr] <= bus.dmem_wdata;
  end

  always @(negedge clk) begin
    if (bus.core_run === 1'b1) begin
      n_runs++;
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("run_insn", 32'(bus.core_instruction),
            32'(exp_q.pop_front()));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_run(output int cyc);
    cyc = 1;
    while (bus.core_run !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("run_seen", 32'(bus.core_run), 32'd1);
  endtask

  task automatic do_done(int n);
    repeat (n) @(negedge clk);
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
  endtask

  task automatic wait_halt();
    int k;
    k = 0;
    while (halted !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("halted", 32'(halted), 32'd1);
  endtask

  initial begin
    int cyc;
    int r0;
    reset                = 1'b1;
    start                = 1'b0;
    bus.core_done        = 1'b0;
    bus.core_en_mem_inst = 1'b0;
    bus.core_en_mem_wr   = 1'b0;
    bus.core_memory_addr = '0;
    bus.core_data_to_mem = '0;
    bus.imem_rdata       = '0;
    bus.dmem_rdata       = '0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h1000 + 16'(i);
      dmem[i] = '0;
    end
    imem[0]     = 16'h0001;
    imem[1]     = 16'h0002;
    imem[2]     = 16'hFFFF;
    dmem[8'h10] = 16'hBEEF;

    repeat (3) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imem_rd", 32'(bus.imem_rd_en), 32'd0);
    chk("rst_run", 32'(bus.core_run), 32'd0);
    chk("rst_dmem_rd", 32'(bus.dmem_rd_en), 32'd0);
    chk("rst_dmem_wr", 32'(bus.dmem_wr_en), 32'd0);
    chk("rst_insn", 32'(bus.core_instruction), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_fetch", 32'(bus.imem_rd_en), 32'd0);

    // program: 1, 2, halt
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    pulse_start();
    chk("fetch_rd_en", 32'(bus.imem_rd_en), 32'd1);
    chk("fetch_addr", 32'(bus.imem_addr), 32'd0);
    wait_run(cyc);
    chk("latency", 32'(cyc), 32'd3);
    do_done(2);
    chk("pc_adv", 32'(pc), 32'd1);
    wait_run(cyc);
    do_done(2);
    wait_halt();
    chk("pc_halt", 32'(pc), 32'd2);
    chk("insn_hold_halt", 32'(bus.core_instruction), 32'h0002);
    chk("runs_prog", 32'(n_runs), 32'd2);
    chk("sb_drain1", 32'(exp_q.size()), 32'd0);

    // load, store, done-vs-load priority
    imem[0] = 16'h0100;
    imem[1] = 16'h0200;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0200);
    pulse_start();
    chk("restart_pc", 32'(pc), 32'd0);
    wait_run(cyc);
    @(negedge clk);
    bus.core_en_mem_inst = 1'b1;
    bus.core_en_mem_wr   = 1'b0;
    bus.core_memory_addr = 16'h0010;
    #1;
    chk("ld_rd_en", 32'(bus.dmem_rd_en), 32'd1);
    chk("ld_addr", 32'(bus.dmem_addr), 32'h10);
    @(negedge clk);
    chk("ld_rd_once", 32'(bus.dmem_rd_en), 32'd0);
    @(negedge clk);
    chk("ld_data", 32'(bus.core_instruction), 32'hBEEF);
    chk("ld_blocked", 32'(bus.dmem_rd_en), 32'd0);
    bus.core_en_mem_inst = 1'b0;
    @(negedge clk);
    chk("ld_hold", 32'(bus.core_instruction), 32'hBEEF);
    chk("ld_pc_hold", 32'(pc), 32'd0);
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("pc_after_ld", 32'(pc), 32'd1);

    wait_run(cyc);
    @(negedge clk);
    bus.core_en_mem_inst = 1'b1;
    bus.core_en_mem_wr   = 1'b1;
    bus.core_memory_addr = 16'hFF20;
    bus.core_data_to_mem = 16'h1234;
    #1;
    chk("st_wr_en", 32'(bus.dmem_wr_en), 32'd1);
    chk("st_addr", 32'(bus.dmem_addr), 32'h20);
    chk("st_wdata", 32'(bus.dmem_wdata), 32'h1234);
    chk("st_no_rd", 32'(bus.dmem_rd_en), 32'd0);
    @(negedge clk);
    bus.core_en_mem_inst = 1'b0;
    bus.core_en_mem_wr   = 1'b0;
    #1;
    chk("st_single", 32'(bus.dmem_wr_en), 32'd0);
    chk("st_mem", 32'(dmem[8'h20]), 32'h1234);
    bus.core_en_mem_inst = 1'b1;
    bus.core_memory_addr = 16'h0010;
    bus.core_done        = 1'b1;
    #1;
    chk("done_prio_no_rd", 32'(bus.dmem_rd_en), 32'd0);
    @(negedge clk);
    bus.core_en_mem_inst = 1'b0;
    bus.core_done        = 1'b0;
    chk("done_prio_pc", 32'(pc), 32'd2);
    wait_halt();
    chk("sb_drain2", 32'(exp_q.size()), 32'd0);

    // full sweep: pc wraps 255 -> 0
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h1000 + 16'(i);
      exp_q.push_back(16'h1000 + 16'(i));
    end
    exp_q.push_back(16'h1000);
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      wait_run(cyc);
      if (i == 200) imem[1] = 16'hFFFF;
      do_done(1);
    end
    chk("pc_wrap", 32'(pc), 32'd0);
    wait_run(cyc);
    do_done(1);
    wait_halt();
    chk("pc_wrap_halt", 32'(pc), 32'd1);
    chk("sb_drain3", 32'(exp_q.size()), 32'd0);
    chk("runs_total", 32'(n_runs), 32'd261);

    // reset while executing
    imem[1] = 16'h1001;
    exp_q.push_back(16'h1000);
    exp_q.push_back(16'h1001);
    pulse_start();
    wait_run(cyc);
    do_done(1);
    wait_run(cyc);
    @(negedge clk);
    chk("pre_rst_pc", 32'(pc), 32'd1);
    bus.core_en_mem_inst = 1'b1;
    bus.core_en_mem_wr   = 1'b1;
    reset                = 1'b1;
    #1;
    chk("rst_cyc_no_wr", 32'(bus.dmem_wr_en), 32'd0);
    @(negedge clk);
    reset                = 1'b0;
    bus.core_en_mem_inst = 1'b0;
    bus.core_en_mem_wr   = 1'b0;
    #1;
    chk("rst_exec_pc", 32'(pc), 32'd0);
    chk("rst_exec_insn", 32'(bus.core_instruction), 32'd0);
    chk("rst_exec_run", 32'(bus.core_run), 32'd0);
    chk("rst_exec_fetch", 32'(bus.imem_rd_en), 32'd0);
    chk("rst_exec_halted", 32'(halted), 32'd0);
    r0 = n_runs;
    repeat (6) @(negedge clk);
    chk("rst_needs_start", 32'(n_runs), 32'(r0));
    imem[1] = 16'hFFFF;
    exp_q.delete();
    exp_q.push_back(16'h1000);
    pulse_start();
    wait_run(cyc);
    do_done(1);
    wait_halt();
    chk("sb_drain4", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
